// File: rtl/buzzer_pattern_driver.sv
// Turns the two 2-bit buzz codes into gated square-wave buzzer drives: continuous tone, beep cadence, or silence.
// Define BUZZ_ALTERNATE_EN to make the right channel beep in anti-phase with the left when both codes request beeping.
module buzzer_pattern_driver #(
    parameter int TONE_HALF_PERIOD = 2500,
    parameter int TICK_DIV         = 10000,
    parameter int BEEP_ON_TICKS    = 100,
    parameter int BEEP_OFF_TICKS   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] left_buzz,
    input  logic [1:0] right_buzz,
    output logic       left_tone,
    output logic       right_tone,
    output logic       left_active,
    output logic       right_active
);

    localparam int TW   = $clog2(TONE_HALF_PERIOD + 1);
    localparam int DW   = $clog2(TICK_DIV + 1);
    localparam int MAXB = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
    localparam int CW   = $clog2(MAXB + 1);

    typedef enum logic [1:0] {IDLE, CONT, BEEP_ON, BEEP_OFF} state_t;

    // Channel index 0 is left, 1 is right.
    logic [1:0]    code_q   [2];
    state_t        state    [2];
    state_t        state_nxt[2];
    logic [CW-1:0] cad      [2];
    logic [CW-1:0] cad_nxt  [2];
    logic [CW-1:0] cad_inc  [2];
    logic          gate     [2];

    logic [TW-1:0] tone_cnt;
    logic          tone_sq;
    logic [DW-1:0] tick_cnt;
    logic          tick;

    assign tick       = (tick_cnt == DW'(TICK_DIV - 1));
    assign cad_inc[0] = cad[0] + 1'b1;
    assign cad_inc[1] = cad[1] + 1'b1;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            tone_cnt     <= '0;
            tone_sq      <= 1'b0;
            tick_cnt     <= '0;
            left_tone    <= 1'b0;
            right_tone   <= 1'b0;
            left_active  <= 1'b0;
            right_active <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                code_q[ch] <= 2'b00;
                state[ch]  <= IDLE;
                cad[ch]    <= '0;
            end
        end else begin
            if (tone_cnt == TW'(TONE_HALF_PERIOD - 1)) begin
                tone_cnt <= '0;
                tone_sq  <= ~tone_sq;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
            tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
            code_q[0]    <= left_buzz;
            code_q[1]    <= right_buzz;
            left_active  <= gate[0];
            right_active <= gate[1];
            left_tone    <= gate[0] & tone_sq;
            right_tone   <= gate[1] & tone_sq;
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= state_nxt[ch];
                cad[ch]   <= cad_nxt[ch];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            state_nxt[ch] = state[ch];
            cad_nxt[ch]   = cad[ch];
            gate[ch]      = (state[ch] == CONT) || (state[ch] == BEEP_ON);
            case (code_q[ch])
                2'b10: begin
                    state_nxt[ch] = CONT;
                    cad_nxt[ch]   = '0;
                end
                2'b01: begin
                    case (state[ch])
                        BEEP_ON: begin
                            if (tick) begin
                                if (cad_inc[ch] == CW'(BEEP_ON_TICKS)) begin
                                    state_nxt[ch] = BEEP_OFF;
                                    cad_nxt[ch]   = '0;
                                end else begin
                                    cad_nxt[ch] = cad_inc[ch];
                                end
                            end
                        end
                        BEEP_OFF: begin
                            if (tick) begin
                                if (cad_inc[ch] == CW'(BEEP_OFF_TICKS)) begin
                                    state_nxt[ch] = BEEP_ON;
                                    cad_nxt[ch]   = '0;
                                end else begin
                                    cad_nxt[ch] = cad_inc[ch];
                                end
                            end
                        end
                        default: begin
                            // Entering beep mode from IDLE or CONT; the tick phase is left as is.
                            state_nxt[ch] = BEEP_ON;
                            cad_nxt[ch]   = '0;
                        end
                    endcase
                end
                default: begin
                    state_nxt[ch] = IDLE;
                    cad_nxt[ch]   = '0;
                end
            endcase
        end
`ifdef BUZZ_ALTERNATE_EN
        // Right FSM parks in IDLE so that leaving alternation restarts its own cadence from scratch.
        if (code_q[0] == 2'b01 && code_q[1] == 2'b01) begin
            state_nxt[1] = IDLE;
            cad_nxt[1]   = '0;
            gate[1]      = (state[0] != BEEP_ON);
        end
`endif
    end

endmodule

// File: tb/tb_buzzer_pattern_driver.sv
// Scoreboard bench for buzzer_pattern_driver: the stimulus process queues hand-derived per-cycle outputs,
// a negedge monitor pops and compares them. Extra alternating-beep scenario when BUZZ_ALTERNATE_EN is defined.
module tb_buzzer_pattern_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] left_buzz = 2'b00;
    logic [1:0] right_buzz = 2'b00;
    logic       left_tone, right_tone, left_active, right_active;

    buzzer_pattern_driver #(
        .TONE_HALF_PERIOD(2),
        .TICK_DIV        (4),
        .BEEP_ON_TICKS   (2),
        .BEEP_OFF_TICKS  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .left_buzz   (left_buzz),
        .right_buzz  (right_buzz),
        .left_tone   (left_tone),
        .right_tone  (right_tone),
        .left_active (left_active),
        .right_active(right_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string tag;
        logic  la;
        logic  lt;
        logic  ra;
        logic  rt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc = 0;
    int   rbase = 3;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;
    bit   checked = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Square-wave level present after edge j, counted from the last reset edge.
    function automatic logic tsq(int j);
        return logic'(((j - rbase) / 2) % 2);
    endfunction

    task automatic push_window(int first, int last, logic la, logic ra, string tag);
        for (int k = first; k <= last; k++) begin
            exp_t x;
            x.cyc = k;
            x.tag = tag;
            x.la  = la;
            x.ra  = ra;
            x.lt  = la & tsq(k - 1);
            x.rt  = ra & tsq(k - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_edge(int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            total++;
            if (e.cyc != cyc ||
                {left_active, left_tone, right_active, right_tone} !== {e.la, e.lt, e.ra, e.rt}) begin
                bad++;
                $display("FAIL %s cyc=%0d exp_cyc=%0d got la/lt/ra/rt=%b%b%b%b want %b%b%b%b",
                         e.tag, cyc, e.cyc, left_active, left_tone, right_active, right_tone,
                         e.la, e.lt, e.ra, e.rt);
            end
        end
        if (done && !checked) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL drain got %0d pending want 0", exp_q.size());
            end
            checked = 1'b1;
        end
    end

    initial begin
        int last_cyc;
        // Reset on edges 1..3, codes 00: everything silent.
        push_window(1, 55, 1'b0, 1'b0, "reset_idle");
        push_window(56, 77, 1'b1, 1'b0, "left_cont");
        push_window(78, 81, 1'b0, 1'b0, "left_release");
        wait_edge(3);
        reset = 1'b0;

        wait_edge(53);
        left_buzz = 2'b10;
        wait_edge(75);
        left_buzz = 2'b00;

        // Right beep: first ON 6 cycles, then OFF 12 / ON 8.
        push_window(82, 87, 1'b0, 1'b1, "right_first_on");
        push_window(88, 99, 1'b0, 1'b0, "right_off1");
        push_window(100, 107, 1'b0, 1'b1, "right_on2");
        push_window(108, 119, 1'b0, 1'b0, "right_off2");
        push_window(120, 127, 1'b0, 1'b1, "right_on3");
        push_window(128, 139, 1'b0, 1'b0, "right_off3");
        push_window(140, 141, 1'b0, 1'b1, "right_on4");
        push_window(142, 145, 1'b0, 1'b0, "right_release");
        wait_edge(79);
        right_buzz = 2'b01;
        wait_edge(139);
        right_buzz = 2'b00;

        // Left beep, switched to continuous mid-OFF; right joins continuous.
        push_window(146, 151, 1'b1, 1'b0, "left_beep_on");
        push_window(152, 157, 1'b0, 1'b0, "left_beep_off");
        push_window(158, 177, 1'b1, 1'b1, "both_cont");
        wait_edge(143);
        left_buzz = 2'b01;
        wait_edge(155);
        left_buzz  = 2'b10;
        right_buzz = 2'b10;

        // One-cycle reset during CONT with codes held.
        push_window(178, 180, 1'b0, 1'b0, "mid_reset");
        wait_edge(177);
        reset = 1'b1;
        wait_edge(178);
        reset = 1'b0;
        rbase = 178;
        push_window(181, 201, 1'b1, 1'b1, "post_reset_cont");
        last_cyc = 201;

`ifdef BUZZ_ALTERNATE_EN
        push_window(202, 203, 1'b1, 1'b1, "alt_entry");
        push_window(204, 210, 1'b1, 1'b0, "alt_l_on1");
        push_window(211, 222, 1'b0, 1'b1, "alt_l_off1");
        push_window(223, 230, 1'b1, 1'b0, "alt_l_on2");
        push_window(231, 242, 1'b0, 1'b1, "alt_l_off2");
        push_window(243, 247, 1'b1, 1'b0, "alt_l_on3");
        push_window(248, 254, 1'b0, 1'b1, "left11_right_fresh_on");
        push_window(255, 266, 1'b0, 1'b0, "left11_right_off");
        wait_edge(201);
        left_buzz  = 2'b01;
        right_buzz = 2'b01;
        wait_edge(245);
        left_buzz = 2'b11;
        last_cyc = 266;
`endif

        wait_edge(last_cyc + 1);
        done = 1'b1;
        wait (checked);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/buzzer_pattern_driver.md
Name: buzzer_pattern_driver

Overview:
Downstream stage of the obstacle-detection decoder. Consumes the two 2-bit buzz codes (00 off, 01 "both close", 10 "close") and converts each into a square-wave tone for one piezo buzzer.
- Code 10: continuous tone.
- Code 01: intermittent tone (beep cadence).
- Code 00 and 11: silence.
One shared tone generator and one shared tick prescaler feed two independent per-channel state machines.

Parameters:
- TONE_HALF_PERIOD, 2500, clock cycles per tone half-period (tone period = 2*TONE_HALF_PERIOD); must be >= 1.
- TICK_DIV, 10000, clock cycles per cadence tick; must be >= 1.
- BEEP_ON_TICKS, 100, ticks the tone is gated on in beep mode; must be >= 1.
- BEEP_OFF_TICKS, 100, ticks the tone is gated off in beep mode; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- left_buzz  input  2  left buzz code from the decoder.
- right_buzz  input  2  right buzz code from the decoder.
- left_tone  output  1  left buzzer drive, registered.
- right_tone  output  1  right buzzer drive, registered.
- left_active  output  1  high while the left channel gate is open, registered.
- right_active  output  1  high while the right channel gate is open, registered.

Behaviour:
- Reset: all outputs 0, tone counter 0, tone_sq 0, tick counter 0, both FSMs IDLE, both input registers 00. Reset asserted mid-beep or mid-tone aborts immediately; outputs are 0 on the cycle after the reset edge.
- Input stage: left_buzz/right_buzz are registered every cycle into code_q (1-cycle latency).
- Tone generator:
  - Free-running counter 0..TONE_HALF_PERIOD-1.
  - At wrap, tone_sq toggles.
  - Never gated and never restarted except by reset.
- Tick prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick pulses for one cycle when the counter equals TICK_DIV-1.
- Per-channel FSM, states IDLE, CONT, BEEP_ON, BEEP_OFF, evaluated from code_q each cycle:
  - code_q 00 or 11 -> IDLE, from any state.
  - code_q 10 -> CONT, from any state.
  - code_q 01 from IDLE or CONT -> BEEP_ON, cadence counter cleared to 0.
  - BEEP_ON: counts ticks; on the tick that makes the count BEEP_ON_TICKS -> BEEP_OFF, counter cleared.
  - BEEP_OFF: on the tick that makes the count BEEP_OFF_TICKS -> BEEP_ON, counter cleared.
  - Staying at 01 never restarts the cadence.
- Gate: open in CONT and BEEP_ON; closed in IDLE and BEEP_OFF.
- Outputs are registered:
  - x_active <= gate.
  - x_tone <= gate & tone_sq.
- Latency: input change at edge N -> code_q at N+1 -> state at N+2 -> outputs at N+3. Total 3 cycles, fixed.
- Cadence boundary: ticks are not realigned on entry, so the first BEEP_ON phase lasts between (BEEP_ON_TICKS-1)*TICK_DIV+1 and BEEP_ON_TICKS*TICK_DIV cycles. All later phases are exactly N*TICK_DIV cycles.
- Simultaneous events: a code change and a tick in the same cycle are resolved by the code change taking priority. Channels are fully independent; both may be in any state together.
- Cadence counter width: $clog2(max(BEEP_ON_TICKS, BEEP_OFF_TICKS)+1). It cannot overflow because it is cleared at each terminal count.

Optional Feature:
- Macro: BUZZ_ALTERNATE_EN.
- Defined: when both code_q values are 01, the right channel does not use its own cadence. Its gate equals the inverse of the left channel's BEEP_ON gate, giving alternating left/right beeps. When either code leaves 01, the right FSM re-enters normally per its code; entering BEEP_ON from that point starts its own cadence fresh.
- Undefined: channels are fully independent as described in Behaviour.

Test Plan:
Bench parameters for all scenarios: TONE_HALF_PERIOD=2, TICK_DIV=4, BEEP_ON_TICKS=2, BEEP_OFF_TICKS=3.
- Reset, both codes 00 -> all outputs 0 for 50 cycles; tone_sq internally toggles every 2 cycles.
- left_buzz=10 at edge N -> left_active=1 from edge N+3; left_tone toggles with period 4 cycles; right_* stay 0.
- right_buzz=01 held 60 cycles -> right_active shows a first ON phase of 5..8 cycles, then repeating OFF 12 / ON 8 cycles.
- left_buzz 01 -> 10 mid-BEEP_OFF -> left_active=1 exactly 3 cycles after the change, continuous thereafter.
- Reset asserted for 1 cycle during CONT on both channels, codes held at 10 -> outputs 0 on the next cycle, then reassert 3 cycles after reset deasserts.
- With BUZZ_ALTERNATE_EN, both codes 01 -> right_active == !left_active at every cycle once both are in beep mode; code 11 on either side -> that channel stays silent.
